ex_stage: RTL and testbench

//  Execute stage of the 5-stage pipeline, directly upstream of the memory stage.

---
 rtl/ex_stage.sv | 182 ++++++++++++++++++
 tb/tb_ex_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative multiply/divide engine,
// registering the result and the memory/writeback controls into EX/MEM.
module ex_stage #(
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        flush,
  input  logic [3:0]  ALUOp,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  input  logic [4:0]  Shamt,
  input  logic [31:0] MemWriteData_i,
  input  logic [4:0]  WriteReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        RegWrite_i,
  input  logic        LUOp_i,
  input  logic [1:0]  MemToReg_i,
  input  logic [31:0] PC_Plus4_i,
  input  logic [31:0] LUData_i,
  output logic        busy,
  output logic [31:0] ALU_S,
  output logic [31:0] MemWriteData,
  output logic [4:0]  WriteReg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  MemToReg,
  output logic [31:0] PC_Plus4,
  output logic        LUOp,
  output logic [31:0] LUData
);

  localparam int unsigned CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [31:0] mwd;
    logic [4:0]  wreg;
    logic        mread;
    logic        mwrite;
    logic        rwrite;
    logic        luop;
    logic [1:0]  m2r;
    logic [31:0] pc4;
    logic [31:0] ludata;
  } ctrl_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    op_q, op_n;
  logic [31:0]   ra, ra_n, rb, rb_n, racc, racc_n;
  ctrl_t         saved, saved_n, outc, outc_n, in_ctrl;
  logic [31:0]   alu_q, alu_n, alu_res;
  logic          is_md;

  // Engine step: mul uses ra=multiplicand, rb=multiplier, racc=product;
  // div uses ra=divisor, rb=dividend/quotient, racc=partial remainder.
  logic [31:0] it_a, it_b, it_acc;
  logic [32:0] div_sh;

  assign in_ctrl = '{mwd: MemWriteData_i, wreg: WriteReg_i, mread: MemRead_i,
                     mwrite: MemWrite_i, rwrite: RegWrite_i, luop: LUOp_i,
                     m2r: MemToReg_i, pc4: PC_Plus4_i, ludata: LUData_i};

  assign is_md = (ALUOp == 4'd11) || (ALUOp == 4'd12) || (ALUOp == 4'd13);

  always_comb begin
    alu_res = OpB;
    case (ALUOp)
      4'd0:  alu_res = OpA + OpB;
      4'd1:  alu_res = OpA - OpB;
      4'd2:  alu_res = OpA & OpB;
      4'd3:  alu_res = OpA | OpB;
      4'd4:  alu_res = OpA ^ OpB;
      4'd5:  alu_res = ~(OpA | OpB);
      4'd6:  alu_res = OpB << Shamt;
      4'd7:  alu_res = OpB >> Shamt;
      4'd8:  alu_res = $signed(OpB) >>> Shamt;
      4'd9:  alu_res = {31'd0, $signed(OpA) < $signed(OpB)};
      4'd10: alu_res = {31'd0, OpA < OpB};
      default: alu_res = OpB;
    endcase
  end

  always_comb begin
    div_sh = {racc, rb[31]};
    if (op_q == 4'd11) begin
      it_acc = racc + (rb[0] ? ra : '0);
      it_a   = ra << 1;
      it_b   = rb >> 1;
    end else begin
      it_a = ra;
      if (div_sh >= {1'b0, ra}) begin
        it_acc = div_sh[31:0] - ra;
        it_b   = {rb[30:0], 1'b1};
      end else begin
        it_acc = div_sh[31:0];
        it_b   = {rb[30:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    ra_n    = ra;
    rb_n    = rb;
    racc_n  = racc;
    saved_n = saved;
    outc_n  = '0;
    alu_n   = '0;
    if (flush) begin
      state_n = IDLE;
    end else if (state == RUN) begin
      ra_n   = it_a;
      rb_n   = it_b;
      racc_n = it_acc;
      if (cnt == '0) begin
        state_n = IDLE;
        outc_n  = saved;
        alu_n   = (op_q == 4'd11 || op_q == 4'd13) ? it_acc : it_b;
      end else begin
        cnt_n = cnt - 1'b1;
      end
    end else if (in_valid) begin
      if (is_md) begin
        state_n = RUN;
        cnt_n   = CW'(MD_CYCLES - 1);
        op_n    = ALUOp;
        ra_n    = (ALUOp == 4'd11) ? OpA : OpB;
        rb_n    = (ALUOp == 4'd11) ? OpB : OpA;
        racc_n  = '0;
        saved_n = in_ctrl;
      end else begin
        outc_n = in_ctrl;
        alu_n  = alu_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      ra    <= '0;
      rb    <= '0;
      racc  <= '0;
      saved <= '0;
      outc  <= '0;
      alu_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
      ra    <= ra_n;
      rb    <= rb_n;
      racc  <= racc_n;
      saved <= saved_n;
      outc  <= outc_n;
      alu_q <= alu_n;
    end
  end

  assign busy         = (state == RUN);
  assign ALU_S        = alu_q;
  assign MemWriteData = outc.mwd;
  assign WriteReg     = outc.wreg;
  assign MemRead      = outc.mread;
  assign MemWrite     = outc.mwrite;
  assign RegWrite     = outc.rwrite;
  assign MemToReg     = outc.m2r;
  assign PC_Plus4     = outc.pc4;
  assign LUOp         = outc.luop;
  assign LUData       = outc.ludata;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes expected writebacks, a monitor
// pops and compares whenever RegWrite is presented.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush;
  logic [3:0]  ALUOp;
  logic [31:0] OpA, OpB, MemWriteData_i, PC_Plus4_i, LUData_i;
  logic [4:0]  Shamt, WriteReg_i;
  logic        MemRead_i, MemWrite_i, RegWrite_i, LUOp_i;
  logic [1:0]  MemToReg_i;
  logic        busy, MemRead, MemWrite, RegWrite, LUOp;
  logic [31:0] ALU_S, MemWriteData, PC_Plus4, LUData;
  logic [4:0]  WriteReg;
  logic [1:0]  MemToReg;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [31:0] pc;
    logic [31:0] mwd;
    logic [1:0]  m2r;
  } exp_t;
  exp_t sb[$];

  ex_stage #(.MD_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
    .ALUOp(ALUOp), .OpA(OpA), .OpB(OpB), .Shamt(Shamt),
    .MemWriteData_i(MemWriteData_i), .WriteReg_i(WriteReg_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i),
    .LUOp_i(LUOp_i), .MemToReg_i(MemToReg_i), .PC_Plus4_i(PC_Plus4_i),
    .LUData_i(LUData_i), .busy(busy), .ALU_S(ALU_S),
    .MemWriteData(MemWriteData), .WriteReg(WriteReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .PC_Plus4(PC_Plus4), .LUOp(LUOp), .LUData(LUData)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: every presented writeback must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (RegWrite === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=0x%08h wr=%0d required=none", ALU_S, WriteReg);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("alu_s", ALU_S, e.alu);
        check("write_reg", {27'd0, WriteReg}, {27'd0, e.wr});
        check("pc_plus4", PC_Plus4, e.pc);
        check("mem_wdata", MemWriteData, e.mwd);
        check("mem_to_reg", {30'd0, MemToReg}, {30'd0, e.m2r});
        check("mem_rw", {30'd0, MemRead, MemWrite}, 32'd0);
      end
    end
  end

  task automatic set_inputs(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] sh, input logic [4:0] wr);
    ALUOp = op; OpA = a; OpB = b; Shamt = sh; WriteReg_i = wr;
    RegWrite_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; LUOp_i = 1'b0;
    MemToReg_i = wr[1:0]; PC_Plus4_i = 32'h400 + {27'd0, wr};
    MemWriteData_i = a ^ b; LUData_i = 32'h1234_0000;
    in_valid = 1'b1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] wr, input logic [31:0] res);
    exp_t e;
    int n;
    @(negedge clk);
    set_inputs(op, a, b, sh, wr);
    e.alu = res; e.wr = wr; e.pc = 32'h400 + {27'd0, wr}; e.mwd = a ^ b; e.m2r = wr[1:0];
    sb.push_back(e);
    if (op >= 4'd11 && op <= 4'd13) begin
      @(posedge clk); #1;
      check("accept_busy", {31'd0, busy}, 32'd1);
      n = 1;
      for (int k = 0; k < 100; k++) begin
        @(posedge clk); #1;
        if (busy !== 1'b1) break;
        n++;
      end
      check("busy_len", n, 32);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0;
    set_inputs(4'd0, 32'd1, 32'd2, 5'd0, 5'd9);
    repeat (3) @(posedge clk);
    #1;
    check("reset_alu", ALU_S, 32'd0);
    check("reset_regwrite", {31'd0, RegWrite}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_pc", PC_Plus4, 32'd0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;

    issue(4'd0,  32'd5,        32'd7,        5'd0, 5'd3,  32'd12);
    issue(4'd1,  32'd3,        32'd5,        5'd0, 5'd4,  32'hFFFF_FFFE);
    issue(4'd5,  32'hF0F0_F0F0, 32'h0F0F_0000, 5'd0, 5'd5,  32'h0000_0F0F);
    issue(4'd9,  32'hFFFF_FFFF, 32'd1,        5'd0, 5'd6,  32'd1);
    issue(4'd10, 32'hFFFF_FFFF, 32'd1,        5'd0, 5'd7,  32'd0);
    issue(4'd8,  32'h8000_0000, 32'h8000_0000, 5'd4, 5'd8,  32'hF800_0000);
    issue(4'd7,  32'h8000_0000, 32'h8000_0000, 5'd4, 5'd9,  32'h0800_0000);
    issue(4'd6,  32'd1,        32'd1,        5'd31, 5'd10, 32'h8000_0000);
    issue(4'd15, 32'd1,        32'hDEAD_BEEF, 5'd0, 5'd11, 32'hDEAD_BEEF);
    issue(4'd11, 32'd7,        32'd6,        5'd0, 5'd12, 32'd42);
    issue(4'd11, 32'h0001_0000, 32'h0001_0000, 5'd0, 5'd13, 32'd0);
    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd14, 32'd1);
    issue(4'd12, 32'd100,      32'd7,        5'd0, 5'd15, 32'd14);
    issue(4'd13, 32'd100,      32'd7,        5'd0, 5'd16, 32'd2);
    issue(4'd12, 32'd9,        32'd0,        5'd0, 5'd17, 32'hFFFF_FFFF);
    issue(4'd13, 32'd9,        32'd0,        5'd0, 5'd18, 32'd9);
    issue(4'd12, 32'hFFFF_FFFF, 32'd1,        5'd0, 5'd19, 32'hFFFF_FFFF);

    // Flush of an idle ADD: nothing may be written.
    @(negedge clk);
    set_inputs(4'd0, 32'd1, 32'd1, 5'd0, 5'd20);
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush_idle_regwrite", {31'd0, RegWrite}, 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;

    // MUL aborted by flush on the 10th busy edge.
    @(negedge clk);
    set_inputs(4'd11, 32'd7, 32'd6, 5'd0, 5'd21);
    @(posedge clk); #1;
    check("flush_accept_busy", {31'd0, busy}, 32'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush_busy_drop", {31'd0, busy}, 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    repeat (40) @(posedge clk);

    // Reset pulse on the 5th busy edge of a MUL.
    @(negedge clk);
    set_inputs(4'd11, 32'd3, 32'd3, 5'd0, 5'd22);
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_alu", ALU_S, 32'd0);
    check("rst_wreg", {27'd0, WriteReg}, 32'd0);
    check("rst_pc", PC_Plus4, 32'd0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    repeat (40) @(posedge clk);

    issue(4'd0, 32'd5, 32'd7, 5'd0, 5'd23, 32'd12);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
